// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared FSM encoding, PID constants and CRC16 helpers for the USB TX packetizer
package usb_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [15:0] CRC_POLY     = 16'hA001;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUAL = 16'hB001;
  // Reflected CRC16 over one byte, LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ CRC_POLY : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: byte-wide USB CRC16 accumulator with synchronous clear and update enable
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  // Clear wins over update so a new packet always starts from the init value
  always_ff @(posedge clk or negedge reset)
    if (!reset) crc <= CRC_INIT;
    else crc <= clr ? CRC_INIT : en ? crc16_byte(crc, data) : crc;
endmodule

// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: frames a PID, payload stream and CRC16 into a byte stream for the PHY
module usb_tx_packetizer
  import usb_tx_pkg::*;
#(
  parameter int MAX_LEN    = 64,
  parameter int HIST_DEPTH = 10,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_data,
  input  logic [3:0]            pid,
  input  logic [LEN_W-1:0]      len,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [HIST_DEPTH-1:0] buff
);
  state_t           state, state_nxt;
  logic [3:0]       pid_q;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             done_nxt, err_nxt, crc_clr, crc_en;
  logic [15:0]      crc;

  assign busy = state != S_IDLE;

  usb_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .data  (in_data),
    .crc   (crc)
  );

  // State, latched header fields, completion pulses and transfer history
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      pid_q <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      buff  <= '0;
    end else begin
      state <= state_nxt;
      pid_q <= crc_clr ? pid : pid_q;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      buff  <= {buff[HIST_DEPTH-2:0], tx_valid && tx_ready};
    end

  // Next state and byte-lane outputs; DATA is a combinational pass-through
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: if (send_data) begin
        if (len > LEN_W'(MAX_LEN)) err_nxt = 1'b1;
        else begin
          state_nxt = S_PID;
          cnt_nxt   = len;
          crc_clr   = 1'b1;
        end
      end
      S_PID: begin
        tx_valid = 1'b1;
        tx_data  = {~pid_q, pid_q};
        done_nxt = tx_ready && pid_q[1:0] == 2'b10;
        if (tx_ready) state_nxt = pid_q[1:0] == 2'b10 ? S_IDLE : cnt != '0 ? S_DATA : S_CRC_LO;
      end
      S_DATA: begin
        tx_valid = in_valid;
        tx_data  = in_data;
        in_ready = tx_ready;
        if (tx_ready && in_valid) begin
          crc_en  = 1'b1;
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state_nxt = S_CRC_LO;
        end else if (tx_ready) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc[7:0];
        if (tx_ready) state_nxt = S_CRC_HI;
      end
      S_CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = ~crc[15:8];
        done_nxt = tx_ready;
        if (tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb_usb_tx_packetizer: directed self-checking bench for the USB TX packetizer
module tb_usb_tx_packetizer;
  logic       clk = 1'b0, reset = 1'b0, send_data = 1'b0, in_valid = 1'b0, tx_ready = 1'b0;
  logic [3:0] pid = 4'h0;
  logic [6:0] len = 7'd0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx_valid, busy, done, err;
  logic [7:0] tx_data;
  logic [9:0] buff;
  int         checks = 0, failures = 0;
  logic [7:0] got [16];
  int         n, idx;
  bit         seen_done, prev_stall;
  logic [7:0] prev_data, pat;
  logic [15:0] r;
  bit         fb;

  usb_tx_packetizer dut (
    .clk       (clk),
    .reset     (reset),
    .send_data (send_data),
    .pid       (pid),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .buff      (buff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] p, input logic [6:0] l);
    pid = p;
    len = l;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    #1;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_tx", 16'({tx_valid, tx_data}), 16'h000);
    chk("rst_pulses", 16'({in_ready, done, err}), 16'h0);
    chk("rst_buff", 16'(buff), 16'h000);
    reset = 1'b1;
    tick();

    // zero-length DATA0 at full rate
    tx_ready = 1'b1;
    send(4'h3, 7'd0);
    #1;
    chk("a_pid", 16'({tx_valid, tx_data}), 16'h1C3);
    chk("a_busy", 16'(busy), 16'h1);
    tick(); #1;
    chk("a_crc_lo", 16'({tx_valid, tx_data}), 16'h100);
    tick(); #1;
    chk("a_crc_hi", 16'({tx_valid, tx_data}), 16'h100);
    tick(); #1;
    chk("a_done", 16'({done, busy, tx_valid}), 16'h4);
    chk("a_buff", 16'(buff), 16'h007);
    tick(); #1;
    chk("a_done_pulse", 16'(done), 16'h0);

    // ACK is a single byte with one stall, no payload consumed
    tx_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    send(4'h2, 7'd5);
    #1;
    chk("b_pid", 16'({tx_valid, tx_data}), 16'h1D2);
    chk("b_in_ready", 16'(in_ready), 16'h0);
    tx_ready = 1'b1;
    tick(); #1;
    chk("b_done", 16'({done, busy, in_ready, tx_valid}), 16'h8);
    in_valid = 1'b0;

    // DATA1 with stalls, CRC verified via residual
    pat = 8'b1011_0010;
    tx_ready = 1'b0;
    in_valid = 1'b1;
    idx = 0;
    n = 0;
    seen_done = 1'b0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    send(4'hB, 7'd4);
    for (int c = 0; c < 60 && !seen_done; c++) begin
      tx_ready = pat[c % 8];
      in_data  = 8'(idx);
      #1;
      if (prev_stall) chk("c_stable", 16'(tx_data), 16'(prev_data));
      if (done) seen_done = 1'b1;
      if (tx_valid && tx_ready && n < 16) begin
        got[n] = tx_data;
        n++;
      end
      if (in_valid && in_ready) idx++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      tick();
    end
    in_valid = 1'b0;
    chk("c_done_seen", 16'(seen_done), 16'h1);
    chk("c_nbytes", 16'(n), 16'd7);
    chk("c_pid", 16'(got[0]), 16'h4B);
    for (int k = 0; k < 4; k++) chk("c_payload", 16'(got[k + 1]), 16'(k));
    r = 16'hFFFF;
    for (int k = 1; k < n; k++)
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ got[k][b];
        r  = r >> 1;
        if (fb) r = r ^ 16'hA001;
      end
    chk("c_residual", r, 16'hB001);

    // oversize length rejected
    tx_ready = 1'b1;
    send(4'h3, 7'd65);
    #1;
    chk("d_err", 16'({err, busy, tx_valid}), 16'h4);
    tick(); #1;
    chk("d_err_pulse", 16'({err, busy, tx_valid}), 16'h0);

    // underrun at byte 2 of 4
    in_valid = 1'b1;
    send(4'h3, 7'd4);
    #1;
    chk("e_pid", 16'({tx_valid, tx_data}), 16'h1C3);
    tick();
    in_data = 8'h10;
    #1;
    chk("e_byte0", 16'({in_ready, tx_valid, tx_data}), 16'h310);
    tick();
    in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    #1;
    chk("e_gap", 16'({in_ready, tx_valid}), 16'h2);
    tick(); #1;
    chk("e_err", 16'({err, busy, tx_valid, done}), 16'h8);
    chk("e_buff", 16'(buff[4:0]), 16'h0E);
    tick(); #1;
    chk("e_idle", 16'({err, busy, tx_valid}), 16'h0);

    // reset during CRC_LO
    tx_ready = 1'b0;
    send(4'h3, 7'd0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    #1;
    chk("f_crc_lo", 16'({tx_valid, tx_data}), 16'h100);
    #1;
    reset = 1'b0;
    #1;
    chk("f_rst_tx", 16'({tx_valid, tx_data}), 16'h000);
    chk("f_rst_flags", 16'({in_ready, busy, done, err}), 16'h0);
    chk("f_rst_buff", 16'(buff), 16'h000);
    tick();
    tick();
    reset = 1'b1;
    tick(); #1;
    chk("f_post_flags", 16'({busy, done, err}), 16'h0);
    tx_ready = 1'b1;
    send(4'h3, 7'd0);
    #1;
    chk("f_pid", 16'({tx_valid, tx_data}), 16'h1C3);
    tick(); #1;
    chk("f_crc_lo2", 16'({tx_valid, tx_data}), 16'h100);
    tick(); #1;
    chk("f_crc_hi2", 16'({tx_valid, tx_data}), 16'h100);
    tick(); #1;
    chk("f_done", 16'({done, busy}), 16'h2);
    chk("f_buff", 16'(buff), 16'h007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_tx_packetizer.md
USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

Interface
REQ-001 Parameter MAX_LEN, default 64: maximum payload bytes per packet.
REQ-002 Parameter HIST_DEPTH, default 10: width of the transfer-history shift register.
REQ-003 Derived constant LEN_W = clog2(MAX_LEN+1): width of len.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 send_data  in  1  start request; sampled only in IDLE.
REQ-007 pid  in  4  packet ID nibble; latched on start.
REQ-008 len  in  LEN_W  payload byte count; latched on start.
REQ-009 in_valid / in_data  in  1 / 8  payload byte stream from the producer.
REQ-010 in_ready  out  1  payload byte consumed on in_valid && in_ready.
REQ-011 tx_ready  in  1  PHY accepts the current byte on tx_valid && tx_ready.
REQ-012 tx_valid / tx_data  out  1 / 8  byte offered to the PHY.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done / err  out  1 / 1  one-cycle completion / error pulses.
REQ-015 buff  out  HIST_DEPTH  history of accepted PHY transfers, buff[0] newest.

Function
REQ-016 States: IDLE, PID, DATA, CRC_LO, CRC_HI; one-hot or binary encoding, taken from the package.
REQ-017 IDLE: tx_valid=0, in_ready=0; send_data=1 with len<=MAX_LEN latches pid and len, clears the CRC to 0xFFFF, and moves to PID.
REQ-018 IDLE with send_data=1 and len>MAX_LEN: err=1 for one cycle; state stays IDLE.
REQ-019 PID: tx_valid=1, tx_data={~pid,pid}; tx_data is held stable until tx_ready.
REQ-020 PID accepted, handshake PID (pid[1:0]==2'b10): done=1 next cycle; return to IDLE; no DATA or CRC bytes are sent.
REQ-021 PID accepted, other PIDs: go to DATA if len>0, else go to CRC_LO.
REQ-022 DATA passes through combinationally: tx_valid=in_valid, tx_data=in_data, in_ready=tx_ready.
REQ-023 DATA transfer: each transfer feeds the byte to the CRC and decrements the remaining-byte counter; the last byte moves to CRC_LO.
REQ-024 DATA underrun (tx_ready=1, in_valid=0): err=1 for one cycle; return to IDLE; tx_valid=0 from that cycle.
REQ-025 CRC: USB CRC16, reflected polynomial 0xA001, init 0xFFFF, byte-wise LSB-first update.
REQ-026 CRC transmission: the complemented CRC is sent low byte in CRC_LO, high byte in CRC_HI.
REQ-027 CRC_HI accepted: done=1 on the following cycle; return to IDLE.
REQ-028 tx_ready is ignored while tx_valid=0; send_data is ignored while busy=1.
REQ-029 buff shifts every clk: buff[0] <= (tx_valid && tx_ready), buff[HIST_DEPTH-1:1] <= buff[HIST_DEPTH-2:0].
REQ-030 Latency: the first PID byte is presented one clk after send_data is sampled.
REQ-031 Timing: packet length in cycles = accepted bytes + tx_ready stall cycles.

Reset
REQ-032 On reset=0, asynchronously: state=IDLE; tx_valid, in_ready, busy, done, err=0; tx_data=0; buff=0; CRC=0xFFFF; counter=0.
REQ-033 Reset asserted mid-packet aborts the packet immediately with no done or err pulse; the first post-reset start behaves as after power-up.

Structure
REQ-034 Shared package usb_tx_pkg holds: state encoding, PID constants, CRC_POLY=0xA001, CRC_INIT=0xFFFF, CRC_RESIDUAL=0xB001.
REQ-035 Sub-module usb_crc16: byte-wide CRC update with clear and enable inputs, instantiated once.

Verification
REQ-036 Zero-length DATA0 (pid=4'h3, len=0), tx_ready=1 -> bytes C3, 00, 00; done pulse one cycle after the last byte.
REQ-037 ACK (pid=4'h2), len=5 -> single byte D2; in_ready stays 0; done follows.
REQ-038 DATA1, len=4, payload 00 01 02 03, random tx_ready stalls -> tx_data stable across stalls; a reference-model CRC over payload+CRC bytes gives residual 0xB001.
REQ-039 len=MAX_LEN+1 -> err pulse, busy stays 0, tx_valid stays 0.
REQ-040 in_valid dropped at byte 2 of 4 while tx_ready=1 -> err pulse, return to IDLE, no CRC bytes sent.
REQ-041 reset asserted during CRC_LO -> all outputs 0 asynchronously; the next zero-length packet is correct; buff contents match the transfer pattern.
